seq_divider: RTL

Sequential unsigned restoring divider. It produces one quotient bit per clock using a shift/conditional-subtract datapath. It is the inverse-operation companion to the array multiplier (add/AND cells): partial remainders go through a controlled subtractor instead of partial products through an adder. It sits beside the multiplier in the arithmetic unit and uses a start/done handshake.

---
 rtl/seq_divider.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request; accepted in IDLE or DONE, ignored while busy
//   dividend     : unsigned dividend, captured on accepted start
//   divisor      : unsigned divisor, captured on accepted start
//   busy         : high while the shift/subtract loop runs (WIDTH cycles)
//   done         : one-cycle pulse, results valid
//   quotient     : result quotient, held until the next operation completes
//   remainder    : result remainder, held likewise
//   div_by_zero  : set when the completed operation had divisor == 0
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q, d;
  logic [WIDTH:0]   r, r_sh, sub, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             borrow, accept, last;
  logic             unused_r_msb;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Shift next dividend bit into the partial remainder, then trial-subtract.
  // The borrow out of the (WIDTH+1)-bit subtract is the compare R' < D.
  assign r_sh            = {r[WIDTH-1:0], q[WIDTH-1]};
  assign {borrow, sub}   = {1'b0, r_sh} - {2'b00, d};
  assign r_nxt           = borrow ? r_sh : sub;
  assign q_nxt           = {q[WIDTH-2:0], ~borrow};

  // A restored remainder is always below D, so its top bit never feeds the
  // next shift; it is kept only so R matches the subtractor width.
  assign unused_r_msb = r[WIDTH];

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && (divisor != '0)) begin
      q   <= dividend;
      d   <= divisor;
      r   <= '0;
      cnt <= '0;
    end else if (accept) begin
      // Zero divisor resolves immediately without running the loop.
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (state == RUN) begin
      q   <= q_nxt;
      r   <= r_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
